conv1d_sched: RTL

CONV1D_SCHED -- requirements
Module: conv1d_sched

---
 rtl/conv1d_pkg.sv | 15 +
 rtl/conv1d_step_ctr.sv | 47 ++++
 rtl/conv1d_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/conv1d_pkg.sv
// Shared constants and scheduler state encoding for the conv1d scheduler and its datapath.
// Combinational definitions only; no latency and no flow control of its own.
package conv1d_pkg;

  localparam int BW          = 8;
  localparam int FILTER_SIZE = 3;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_LOAD  = 2'd1;
  localparam sched_state_t ST_RUN   = 2'd2;
  localparam sched_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/conv1d_step_ctr.sv
// Nested filter/position step counter. It advances one position per enabled cycle and decodes pad and last flags.
// Outputs are registered indices. The counter holds when en is low and clears itself after the final step.
module conv1d_step_ctr
  import conv1d_pkg::*;
#(
  parameter int FRAME_SIZE  = 50,
  parameter int NUM_FILTERS = 8,
  parameter int FW          = 3,
  parameter int PW          = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [FW-1:0] filter_idx,
  output logic [PW-1:0] pos,
  output logic          pad_l,
  output logic          pad_r,
  output logic          last
);

  logic pos_last;
  logic filt_last;

  assign pos_last  = (pos == PW'(FRAME_SIZE - 1));
  assign filt_last = (filter_idx == FW'(NUM_FILTERS - 1));
  assign last      = pos_last & filt_last;
  assign pad_l     = (pos == '0);
  assign pad_r     = pos_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filter_idx <= '0;
      pos        <= '0;
    end else if (en) begin
      if (last) begin
        filter_idx <= '0;
        pos        <= '0;
      end else if (pos_last) begin
        filter_idx <= filter_idx + FW'(1);
        pos        <= '0;
      end else begin
        pos <= pos + PW'(1);
      end
    end
  end

endmodule

// File: rtl/conv1d_sched.sv
// Frame scheduler: load samples -> NUM_FILTERS*FRAME_SIZE steps -> PIPE_LAT drain; ready_o low outside IDLE/LOAD,
// steps hold on step_ready_i stall. Optional frame-length checking via CONV1D_SCHED_LEN_CHECK_EN.
module conv1d_sched
  import conv1d_pkg::*;
#(
  parameter int FRAME_SIZE  = 50,
  parameter int NUM_FILTERS = 8,
  parameter int PIPE_LAT    = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i_n,
  input  logic                           valid_i,
  input  logic                           last_i,
  output logic                           ready_o,
  output logic                           load_o,
  output logic                           step_valid_o,
  input  logic                           step_ready_i,
  output logic [$clog2(NUM_FILTERS)-1:0] filter_idx_o,
  output logic [$clog2(FRAME_SIZE)-1:0]  pos_idx_o,
  output logic                           pad_l_o,
  output logic                           pad_r_o,
  output logic                           last_o,
  output logic                           done_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int FW = $clog2(NUM_FILTERS);
  localparam int PW = $clog2(FRAME_SIZE);
  localparam int CW = $clog2(FRAME_SIZE + 1);
  localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  sched_state_t  state;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] next_cnt;
  logic [DW-1:0] drain_cnt;
  logic          accept;
  logic          in_run;
  logic          step_hs;
  logic          end_of_frame;

  logic [FW-1:0] ctr_filter;
  logic [PW-1:0] ctr_pos;
  logic          ctr_pad_l;
  logic          ctr_pad_r;
  logic          ctr_last;

  assign ready_o = rst_i_n & ((state == ST_IDLE) | (state == ST_LOAD));
  assign accept  = valid_i & ready_o;
  assign load_o  = accept;
  assign in_run  = rst_i_n & (state == ST_RUN);
  assign step_hs = in_run & step_ready_i;

  // The first beat of a frame always counts as 1; later beats saturate at FRAME_SIZE.
  always_comb begin
    next_cnt = CW'(1);
    if (state != ST_IDLE) begin
      if (sample_cnt == CW'(FRAME_SIZE)) next_cnt = sample_cnt;
      else                               next_cnt = sample_cnt + CW'(1);
    end
  end

`ifdef CONV1D_SCHED_LEN_CHECK_EN
  logic err_q;
  logic len_err;

  // A full-length frame must end exactly on the FRAME_SIZE-th beat; either mismatch is an error.
  assign end_of_frame = last_i | (next_cnt == CW'(FRAME_SIZE));
  assign len_err      = accept & (last_i ^ (next_cnt == CW'(FRAME_SIZE)));
  assign err_o        = rst_i_n & err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i_n)     err_q <= 1'b0;
    else if (len_err) err_q <= 1'b1;
  end
`else
  assign end_of_frame = last_i;
  assign err_o        = 1'b0;
`endif

  conv1d_step_ctr #(
    .FRAME_SIZE  (FRAME_SIZE),
    .NUM_FILTERS (NUM_FILTERS),
    .FW          (FW),
    .PW          (PW)
  ) u_step_ctr (
    .clk        (clk_i),
    .rst_n      (rst_i_n),
    .en         (step_hs),
    .filter_idx (ctr_filter),
    .pos        (ctr_pos),
    .pad_l      (ctr_pad_l),
    .pad_r      (ctr_pad_r),
    .last       (ctr_last)
  );

  assign step_valid_o = in_run;
  assign filter_idx_o = {FW{rst_i_n}} & ctr_filter;
  assign pos_idx_o    = {PW{rst_i_n}} & ctr_pos;
  assign pad_l_o      = in_run & ctr_pad_l;
  assign pad_r_o      = in_run & ctr_pad_r;
  assign last_o       = in_run & ctr_last;
  assign done_o       = rst_i_n & (state == ST_DRAIN) & (drain_cnt == '0);
  assign busy_o       = rst_i_n & (state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_i_n) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            sample_cnt <= next_cnt;
            state      <= end_of_frame ? ST_RUN : ST_LOAD;
          end
        end
        ST_RUN: begin
          if (step_hs && ctr_last) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(PIPE_LAT);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) state <= ST_IDLE;
          else                 drain_cnt <= drain_cnt - DW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
